// File: rtl/ps2_host_transmitter_if.sv
// Command request/status bundle between a PS/2 command issuer (master)
// and the host-to-device transmitter (slave).
interface ps2_host_transmitter_if;
    logic [7:0] the_command;
    logic       send_command;
    logic       busy;
    logic       command_was_sent;
    logic       error_timeout;
    logic       error_no_ack;

    modport master (
        output the_command,
        output send_command,
        input  busy,
        input  command_was_sent,
        input  error_timeout,
        input  error_no_ack
    );

    modport slave (
        input  the_command,
        input  send_command,
        output busy,
        output command_was_sent,
        output error_timeout,
        output error_no_ack
    );
endinterface

// File: rtl/ps2_host_transmitter.sv
// PS/2 host-to-device command transmitter: request-to-send, 11-bit frame on
// device clock edges, ACK check, and one-cycle done/error reporting.
module ps2_host_transmitter #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned XFER_TIMEOUT   = 100000
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   ps2_clk_in,
    input  logic                   ps2_dat_in,
    output logic                   ps2_clk_oe,
    output logic                   ps2_dat_oe,
    ps2_host_transmitter_if.slave  host
);

    localparam int unsigned MAX_TO  = (START_TIMEOUT > XFER_TIMEOUT) ? START_TIMEOUT : XFER_TIMEOUT;
    localparam int unsigned CNT_TOP = (MAX_TO > INHIBIT_CYCLES) ? MAX_TO : INHIBIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_TOP + 1);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_t CNT_SAT   = {CNT_W{1'b1}};
    localparam cnt_t INH_LAST  = cnt_t'(INHIBIT_CYCLES - 1);
    localparam cnt_t INH_START = cnt_t'(INHIBIT_CYCLES - 2);
    localparam cnt_t START_LIM = cnt_t'(START_TIMEOUT);
    localparam cnt_t XFER_LIM  = cnt_t'(XFER_TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_RTS      = 3'd2,
        ST_DATA     = 3'd3,
        ST_ACK      = 3'd4,
        ST_RELEASE  = 3'd5,
        ST_ERR_TO   = 3'd6,
        ST_ERR_NACK = 3'd7
    } state_t;

    state_t     state_q,      state_d;
    cnt_t       cnt_q,        cnt_d;
    logic [9:0] frame_q,      frame_d;
    logic [3:0] bit_idx_q,    bit_idx_d;
    logic [1:0] clk_sync_q,   clk_sync_d;
    logic [1:0] dat_sync_q,   dat_sync_d;
    logic       clk_prev_q,   clk_prev_d;
    logic       clk_oe_q,     clk_oe_d;
    logic       dat_oe_q,     dat_oe_d;
    logic       busy_q,       busy_d;
    logic       sent_q,       sent_d;
    logic       err_to_q,     err_to_d;
    logic       err_nack_q,   err_nack_d;

    logic       clk_fall_s;
    logic       timeout_s;
    cnt_t       cnt_inc_s;

    // Pad synchronizers plus the previous synchronized clock for edge detect.
    always_comb begin
        clk_sync_d = {clk_sync_q[0], ps2_clk_in};
        dat_sync_d = {dat_sync_q[0], ps2_dat_in};
        clk_prev_d = clk_sync_q[1];
    end

    // Saturating cycle counter and the state-dependent timeout limit.
    always_comb begin
        clk_fall_s = clk_prev_q & ~clk_sync_q[1];
        cnt_inc_s  = (cnt_q == CNT_SAT) ? cnt_q : (cnt_q + cnt_t'(1));
        case (state_q)
            ST_RTS:                       timeout_s = (cnt_inc_s >= START_LIM);
            ST_DATA, ST_ACK, ST_RELEASE:  timeout_s = (cnt_inc_s >= XFER_LIM);
            default:                      timeout_s = 1'b0;
        endcase
    end

    // Next-state and registered-output logic; a timeout beats a same-cycle edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_inc_s;
        frame_d    = frame_q;
        bit_idx_d  = bit_idx_q;
        clk_oe_d   = clk_oe_q;
        dat_oe_d   = dat_oe_q;
        busy_d     = busy_q;
        sent_d     = 1'b0;
        err_to_d   = 1'b0;
        err_nack_d = 1'b0;

        if (timeout_s) begin
            state_d  = ST_ERR_TO;
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            err_to_d = 1'b1;
            cnt_d    = '0;
        end else begin
            case (state_q)
                // The error states are the pulse cycle; lines are already free,
                // so a new request may be taken here just as in IDLE.
                ST_IDLE, ST_ERR_TO, ST_ERR_NACK: begin
                    clk_oe_d  = 1'b0;
                    dat_oe_d  = 1'b0;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    bit_idx_d = 4'd0;
                    if (host.send_command) begin
                        frame_d  = {1'b1, ~^host.the_command, host.the_command};
                        state_d  = ST_INHIBIT;
                        busy_d   = 1'b1;
                        clk_oe_d = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end

                // Clock held low for INHIBIT_CYCLES; start bit overlaps the last one.
                ST_INHIBIT: begin
                    clk_oe_d = 1'b1;
                    if (cnt_q >= INH_LAST) begin
                        clk_oe_d = 1'b0;
                        dat_oe_d = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_RTS;
                    end else if (cnt_q >= INH_START) begin
                        dat_oe_d = 1'b1;
                    end else begin
                        dat_oe_d = 1'b0;
                    end
                end

                ST_RTS: begin
                    if (clk_fall_s) begin
                        dat_oe_d  = ~frame_q[0];
                        bit_idx_d = 4'd1;
                        cnt_d     = '0;
                        state_d   = ST_DATA;
                    end else begin
                        dat_oe_d  = 1'b1;
                    end
                end

                // Index 8 is parity, index 9 the stop bit (line released).
                ST_DATA: begin
                    if (clk_fall_s) begin
                        dat_oe_d = ~frame_q[bit_idx_q];
                        if (bit_idx_q >= 4'd9) begin
                            state_d = ST_ACK;
                        end else begin
                            bit_idx_d = bit_idx_q + 4'd1;
                        end
                    end else begin
                        dat_oe_d = dat_oe_q;
                    end
                end

                ST_ACK: begin
                    if (clk_fall_s) begin
                        if (dat_sync_q[1] == 1'b0) begin
                            state_d    = ST_RELEASE;
                        end else begin
                            state_d    = ST_ERR_NACK;
                            clk_oe_d   = 1'b0;
                            dat_oe_d   = 1'b0;
                            busy_d     = 1'b0;
                            err_nack_d = 1'b1;
                            cnt_d      = '0;
                        end
                    end else begin
                        dat_oe_d = 1'b0;
                    end
                end

                ST_RELEASE: begin
                    if (clk_sync_q[1] && dat_sync_q[1]) begin
                        state_d  = ST_IDLE;
                        clk_oe_d = 1'b0;
                        dat_oe_d = 1'b0;
                        busy_d   = 1'b0;
                        sent_d   = 1'b1;
                        cnt_d    = '0;
                    end else begin
                        dat_oe_d = 1'b0;
                    end
                end

                default: begin
                    state_d  = ST_IDLE;
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    busy_d   = 1'b0;
                    cnt_d    = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            frame_q    <= 10'd0;
            bit_idx_q  <= 4'd0;
            clk_sync_q <= 2'b00;
            dat_sync_q <= 2'b00;
            clk_prev_q <= 1'b0;
            clk_oe_q   <= 1'b0;
            dat_oe_q   <= 1'b0;
            busy_q     <= 1'b0;
            sent_q     <= 1'b0;
            err_to_q   <= 1'b0;
            err_nack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            frame_q    <= frame_d;
            bit_idx_q  <= bit_idx_d;
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            clk_prev_q <= clk_prev_d;
            clk_oe_q   <= clk_oe_d;
            dat_oe_q   <= dat_oe_d;
            busy_q     <= busy_d;
            sent_q     <= sent_d;
            err_to_q   <= err_to_d;
            err_nack_q <= err_nack_d;
        end
    end

    assign ps2_clk_oe            = clk_oe_q;
    assign ps2_dat_oe            = dat_oe_q;
    assign host.busy             = busy_q;
    assign host.command_was_sent = sent_q;
    assign host.error_timeout    = err_to_q;
    assign host.error_no_ack     = err_nack_q;

endmodule
